cook_controller: RTL and testbench

COOK_CONTROLLER -- requirements
Module: cook_controller

---
 rtl/cook_controller_pkg.sv | 54 +++++
 rtl/cook_controller_if.sv | 25 ++
 rtl/cook_controller_btn_edge.sv | 33 +++
 rtl/cook_controller.sv | 126 ++++++++++++
 tb/tb_cook_controller.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cook_controller_pkg.sv
// rtl/cook_controller_pkg.sv - shared state encodings, BCD digit width and time helpers
package cook_controller_pkg;

    localparam int DIGIT_W  = 4;
    localparam int NUM_KEYS = 10;

    typedef logic [DIGIT_W-1:0] bcd_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_COOKING = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    typedef struct packed {
        bcd_t min;
        bcd_t tens;
        bcd_t ones;
    } cook_time_t;

    // A key press counts only when exactly one digit is down.
    function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
        return (v != '0) && ((v & (v - {{(NUM_KEYS-1){1'b0}}, 1'b1})) == '0);
    endfunction

    function automatic bcd_t onehot_digit(input logic [NUM_KEYS-1:0] v);
        bcd_t d;
        d = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (v[i]) d = bcd_t'(i);
        end
        return d;
    endfunction

    // One-second countdown; entered tens digits above 5 simply count down as-is.
    function automatic cook_time_t time_dec(input cook_time_t t);
        cook_time_t r;
        r = t;
        if (t.ones != '0) begin
            r.ones = t.ones - bcd_t'(1);
        end else if (t.tens != '0) begin
            r.tens = t.tens - bcd_t'(1);
            r.ones = bcd_t'(9);
        end else if (t.min != '0) begin
            r.min  = t.min - bcd_t'(1);
            r.tens = bcd_t'(5);
            r.ones = bcd_t'(9);
        end
        return r;
    endfunction

endpackage

// File: rtl/cook_controller_if.sv
// rtl/cook_controller_if.sv - front-panel and display bundle between panel and controller
interface cook_controller_if;
    import cook_controller_pkg::*;

    logic [NUM_KEYS-1:0] kbd;
    logic                startn;
    logic                stopn;
    logic                clearn;
    logic                door_closed;
    bcd_t                min_bcd;
    bcd_t                sec_tens_bcd;
    bcd_t                sec_ones_bcd;
    logic                mag_on;
    logic                done;

    modport master (
        output kbd, startn, stopn, clearn, door_closed,
        input  min_bcd, sec_tens_bcd, sec_ones_bcd, mag_on, done
    );

    modport slave (
        input  kbd, startn, stopn, clearn, door_closed,
        output min_bcd, sec_tens_bcd, sec_ones_bcd, mag_on, done
    );
endinterface

// File: rtl/cook_controller_btn_edge.sv
// rtl/cook_controller_btn_edge.sv - registered press detector (all-idle to active)
module btn_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] din,
    output logic [W-1:0] press
);

    logic [W-1:0] hist_q, hist_d;
    logic [W-1:0] press_q, press_d;

    // Report the new input pattern only when the previous sample was fully idle.
    always_comb begin
        hist_d  = din;
        press_d = (hist_q == '0) ? din : '0;
    end

    // History resets idle so releasing reset never looks like a press.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist_q  <= '0;
            press_q <= '0;
        end else begin
            hist_q  <= hist_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/cook_controller.sv
// rtl/cook_controller.sv - microwave cook timer: keypad entry, countdown and magnetron control
module cook_controller
    import cook_controller_pkg::*;
#(
    parameter int CLK_HZ = 100
) (
    input  logic              clk,
    input  logic              rstn,
    cook_controller_if.slave  bus
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

    logic [NUM_KEYS-1:0] key_press;
    logic                start_ev;
    logic                stop_ev;
    logic                clear_ev;
    logic                key_ev;
    bcd_t                key_digit;

    state_t              state_q, state_d;
    cook_time_t          tm_q, tm_d;
    cook_time_t          tm_dec;
    logic [PW-1:0]       presc_q, presc_d;
    logic                done_q, done_d;

    btn_edge #(.W(NUM_KEYS)) u_kbd_edge (
        .clk   (clk),
        .rstn  (rstn),
        .din   (bus.kbd),
        .press (key_press)
    );

    btn_edge #(.W(1)) u_start_edge (
        .clk   (clk),
        .rstn  (rstn),
        .din   (~bus.startn),
        .press (start_ev)
    );

    btn_edge #(.W(1)) u_stop_edge (
        .clk   (clk),
        .rstn  (rstn),
        .din   (~bus.stopn),
        .press (stop_ev)
    );

    btn_edge #(.W(1)) u_clear_edge (
        .clk   (clk),
        .rstn  (rstn),
        .din   (~bus.clearn),
        .press (clear_ev)
    );

    assign key_ev    = is_onehot(key_press);
    assign key_digit = onehot_digit(key_press);
    assign tm_dec    = time_dec(tm_q);

    // Next-state: strict event priority clear > stop > door > start > key.
    // While cooking, start and keys are ignored so the countdown keeps running.
    always_comb begin
        state_d = state_q;
        tm_d    = tm_q;
        presc_d = '0;
        done_d  = 1'b0;
        if (clear_ev) begin
            state_d = ST_IDLE;
            tm_d    = '0;
        end else if (stop_ev) begin
            if (state_q == ST_COOKING) begin
                state_d = ST_PAUSED;
            end else begin
                state_d = ST_IDLE;
                tm_d    = '0;
            end
        end else if (state_q == ST_COOKING) begin
            if (!bus.door_closed) begin
                state_d = ST_PAUSED;
            end else if (presc_q == PRESC_LAST) begin
                tm_d = tm_dec;
                if (tm_dec == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else if (start_ev) begin
            if ((state_q == ST_ENTRY || state_q == ST_PAUSED) &&
                bus.door_closed && (tm_q != '0)) begin
                state_d = ST_COOKING;
            end
        end else if (key_ev) begin
            if (state_q == ST_IDLE || state_q == ST_ENTRY || state_q == ST_DONE) begin
                state_d   = ST_ENTRY;
                tm_d.min  = tm_q.tens;
                tm_d.tens = tm_q.ones;
                tm_d.ones = key_digit;
            end
        end
    end

    // Controller state, time digits, prescaler and completion pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            tm_q    <= '0;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tm_q    <= tm_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    // Magnetron follows the door directly so an opening door cuts power at once.
    assign bus.mag_on       = (state_q == ST_COOKING) && bus.door_closed;
    assign bus.done         = done_q;
    assign bus.min_bcd      = tm_q.min;
    assign bus.sec_tens_bcd = tm_q.tens;
    assign bus.sec_ones_bcd = tm_q.ones;

endmodule

// File: tb/tb_cook_controller.sv
// tb/tb_cook_controller.sv - scoreboard bench for cook_controller
module tb_cook_controller;

    typedef struct {
        string       name;
        int          at;
        logic [11:0] dig;
        logic        mag;
        logic        dn;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;
    int   checks   = 0;
    int   failures = 0;
    bit   end_req  = 1'b0;

    exp_t exp_q[$];
    int   done_q[$];

    cook_controller_if bus ();

    cook_controller #(.CLK_HZ(100)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_at(input string name, input int at, input logic [11:0] dig,
                             input logic mag, input logic dn);
        exp_t e;
        e.name = name;
        e.at   = at;
        e.dig  = dig;
        e.mag  = mag;
        e.dn   = dn;
        exp_q.push_back(e);
    endtask

    task automatic press(input logic [9:0] k, input logic s, input logic p, input logic c);
        bus.kbd    = k;
        bus.startn = ~s;
        bus.stopn  = ~p;
        bus.clearn = ~c;
        step(1);
        bus.kbd    = '0;
        bus.startn = 1'b1;
        bus.stopn  = 1'b1;
        bus.clearn = 1'b1;
        step(1);
    endtask

    task automatic key(input int d);
        logic [9:0] k;
        k = 10'd1 << d;
        press(k, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic start_btn();
        press('0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic stop_btn();
        press('0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic clear_btn();
        press('0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: pops expectations as their cycle arrives and checks done pulses.
    initial begin
        exp_t        m_e;
        logic [11:0] m_got;
        int          m_at;
        forever begin
            @(negedge clk);
            m_got = {bus.min_bcd, bus.sec_tens_bcd, bus.sec_ones_bcd};
            while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                m_e = exp_q.pop_front();
                checks++;
                if (m_e.at != cyc || m_got !== m_e.dig || bus.mag_on !== m_e.mag ||
                    bus.done !== m_e.dn) begin
                    failures++;
                    $display("FAIL %s cyc=%0d: got time=%h mag_on=%b done=%b required time=%h mag_on=%b done=%b at cyc %0d",
                             m_e.name, cyc, m_got, bus.mag_on, bus.done, m_e.dig, m_e.mag, m_e.dn, m_e.at);
                end
            end
            if (bus.done === 1'b1) begin
                checks++;
                if (done_q.size() == 0) begin
                    failures++;
                    $display("FAIL done_unexpected: got done=1 at cyc %0d required done=0", cyc);
                end else begin
                    m_at = done_q.pop_front();
                    if (m_at != cyc) begin
                        failures++;
                        $display("FAIL done_cycle: got done at cyc %0d required cyc %0d", cyc, m_at);
                    end
                end
            end
            if (end_req) begin
                if (exp_q.size() != 0 || done_q.size() != 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pending: got %0d unchecked expectations required 0",
                             exp_q.size() + done_q.size());
                end
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of stimulus required end before time limit");
        $fatal(1);
    end

    // Stimulus
    initial begin
        int s;
        bus.kbd         = '0;
        bus.startn      = 1'b1;
        bus.stopn       = 1'b1;
        bus.clearn      = 1'b1;
        bus.door_closed = 1'b1;

        rstn = 1'b0;
        step(3);
        expect_at("reset_state", cyc, 12'h000, 1'b0, 1'b0);
        rstn = 1'b1;
        step(2);
        expect_at("reset_release", cyc, 12'h000, 1'b0, 1'b0);

        // 0:12 full run to completion
        key(1); key(2);
        expect_at("t1_entry", cyc, 12'h012, 1'b0, 1'b0);
        start_btn();
        s = cyc;
        expect_at("t1_start", s, 12'h012, 1'b1, 1'b0);
        expect_at("t1_pre_tick", s + 99, 12'h012, 1'b1, 1'b0);
        expect_at("t1_first_tick", s + 100, 12'h011, 1'b1, 1'b0);
        expect_at("t1_last_sec", s + 1199, 12'h001, 1'b1, 1'b0);
        expect_at("t1_done", s + 1200, 12'h000, 1'b0, 1'b1);
        done_q.push_back(s + 1200);
        expect_at("t1_done_one_cycle", s + 1201, 12'h000, 1'b0, 1'b0);
        step(1202);
        key(5);
        expect_at("t1_key_in_done", cyc, 12'h005, 1'b0, 1'b0);
        stop_btn();
        expect_at("t1_stop_entry_idle", cyc, 12'h000, 1'b0, 1'b0);

        // 1:00 borrow, then 0:72 with out-of-range tens
        key(1); key(0); key(0);
        expect_at("t2_entry_100", cyc, 12'h100, 1'b0, 1'b0);
        start_btn();
        s = cyc;
        expect_at("t2_start_100", s, 12'h100, 1'b1, 1'b0);
        expect_at("t2_borrow_059", s + 100, 12'h059, 1'b1, 1'b0);
        step(100);
        stop_btn();
        expect_at("t2_stop_pause", cyc, 12'h059, 1'b0, 1'b0);
        clear_btn();
        expect_at("t2_clear", cyc, 12'h000, 1'b0, 1'b0);
        key(7); key(2);
        expect_at("t2_entry_072", cyc, 12'h072, 1'b0, 1'b0);
        start_btn();
        s = cyc;
        expect_at("t2_start_072", s, 12'h072, 1'b1, 1'b0);
        step(20);
        key(4);
        expect_at("t2_key_ignored", cyc, 12'h072, 1'b1, 1'b0);
        expect_at("t2_071", s + 100, 12'h071, 1'b1, 1'b0);
        expect_at("t2_069", s + 300, 12'h069, 1'b1, 1'b0);
        expect_at("t2_last_sec", s + 7199, 12'h001, 1'b1, 1'b0);
        expect_at("t2_done", s + 7200, 12'h000, 1'b0, 1'b1);
        done_q.push_back(s + 7200);
        expect_at("t2_done_one_cycle", s + 7201, 12'h000, 1'b0, 1'b0);
        step(s + 7202 - cyc);

        // 1:29, door opens on the cycle a decrement is due
        clear_btn();
        key(1); key(2); key(9);
        expect_at("t3_entry_129", cyc, 12'h129, 1'b0, 1'b0);
        start_btn();
        s = cyc;
        expect_at("t3_start", s, 12'h129, 1'b1, 1'b0);
        step(399);
        bus.door_closed = 1'b0;
        expect_at("t3_door_open_mag", s + 399, 12'h126, 1'b0, 1'b0);
        expect_at("t3_tick_dropped", s + 400, 12'h126, 1'b0, 1'b0);
        step(11);
        bus.door_closed = 1'b1;
        expect_at("t3_door_close_held", cyc, 12'h126, 1'b0, 1'b0);
        step(30);
        start_btn();
        s = cyc;
        expect_at("t3_resume", s, 12'h126, 1'b1, 1'b0);
        expect_at("t3_resume_pre_tick", s + 99, 12'h126, 1'b1, 1'b0);
        expect_at("t3_resume_tick", s + 100, 12'h125, 1'b1, 1'b0);
        step(101);
        clear_btn();
        expect_at("t3_clear", cyc, 12'h000, 1'b0, 1'b0);

        // 0:35 stop, stop again, clear while cooking, start at 0:00
        key(3); key(5);
        start_btn();
        step(50);
        stop_btn();
        expect_at("t4_paused", cyc, 12'h035, 1'b0, 1'b0);
        step(200);
        expect_at("t4_paused_held", cyc, 12'h035, 1'b0, 1'b0);
        stop_btn();
        expect_at("t4_stop_paused_idle", cyc, 12'h000, 1'b0, 1'b0);
        key(3); key(5);
        start_btn();
        step(10);
        clear_btn();
        expect_at("t4_clear_cooking", cyc, 12'h000, 1'b0, 1'b0);
        start_btn();
        expect_at("t4_start_zero", cyc, 12'h000, 1'b0, 1'b0);
        step(150);
        expect_at("t4_start_zero_later", cyc, 12'h000, 1'b0, 1'b0);

        // Four-key shift, multi-key rejection, clear beats start
        key(1); key(2); key(3); key(4);
        expect_at("t5_shift_234", cyc, 12'h234, 1'b0, 1'b0);
        bus.kbd = 10'b0000000110;
        step(1);
        bus.kbd = 10'b0000000010;
        step(1);
        bus.kbd = '0;
        step(2);
        expect_at("t5_multikey_ignored", cyc, 12'h234, 1'b0, 1'b0);
        press('0, 1'b1, 1'b0, 1'b1);
        expect_at("t5_clear_start", cyc, 12'h000, 1'b0, 1'b0);
        step(120);
        expect_at("t5_clear_start_later", cyc, 12'h000, 1'b0, 1'b0);

        // Asynchronous reset mid-cook
        key(4); key(5);
        start_btn();
        expect_at("t6_cooking", cyc, 12'h045, 1'b1, 1'b0);
        step(30);
        rstn = 1'b0;
        expect_at("t6_async_reset", cyc, 12'h000, 1'b0, 1'b0);
        step(3);
        rstn = 1'b1;
        step(150);
        expect_at("t6_after_release", cyc, 12'h000, 1'b0, 1'b0);

        step(2);
        end_req = 1'b1;
    end

endmodule
